// File: rtl/cla_seq_adder_ctrl_pkg.sv
// Shared types and sizing helpers for the nibble-serial carry-lookahead adder.
// Step count and index width are both derived from the operand width.
package cla_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int NIBBLE = 4;

    function automatic int calc_steps(input int width);
        return width / NIBBLE;
    endfunction

    // Index width never drops below one bit, even for a single-nibble adder.
    function automatic int calc_idx_w(input int width);
        int steps;
        steps = width / NIBBLE;
        return (steps <= 1) ? 1 : $clog2(steps);
    endfunction

endpackage

// File: rtl/cla_seq_adder_ctrl_if.sv
// Requester-side bus of the sequential adder: start/operands in, status/result out.
// The master modport is used by the requester and the slave modport by the controller.
interface cla_seq_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             hold;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, hold, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, hold, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/cla_seq_adder_ctrl_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice shared by every nibble step.
// All carries come from generate/propagate terms; none ripple.
module cla4_slice (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_s,
    output logic       o_cout
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_s    = w_p ^ w_c[3:0];
    assign o_cout = w_c[4];
endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Nibble-serial WIDTH-bit adder: one shared CLA slice, LS nibble first, carry registered
// between steps; owns operand capture, result assembly and done signalling.
module cla_seq_adder_ctrl
    import cla_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cla_seq_adder_ctrl_if.slave  bus
);
    localparam int N     = calc_steps(WIDTH);
    localparam int IDX_W = calc_idx_w(WIDTH);

    if ((WIDTH % NIBBLE) != 0 || WIDTH < NIBBLE) begin : g_bad_width
        $fatal(1, "cla_seq_adder_ctrl: WIDTH must be a positive multiple of 4");
    end

    state_e             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_busy;
    logic               r_done;

    logic [3:0]         w_slice_a;
    logic [3:0]         w_slice_b;
    logic [3:0]         w_slice_s;
    logic               w_slice_cout;
    logic               w_last;

    assign w_slice_a = r_a[{r_idx, 2'b00} +: NIBBLE];
    assign w_slice_b = r_b[{r_idx, 2'b00} +: NIBBLE];
    assign w_last    = (r_idx == IDX_W'(N - 1));

    cla4_slice u_slice (
        .i_a    (w_slice_a),
        .i_b    (w_slice_b),
        .i_cin  (r_carry),
        .o_s    (w_slice_s),
        .o_cout (w_slice_cout)
    );

    // Control FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= {IDX_W{1'b0}};
            r_a     <= {WIDTH{1'b0}};
            r_b     <= {WIDTH{1'b0}};
            r_carry <= 1'b0;
            r_sum   <= {WIDTH{1'b0}};
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= bus.cin;
                        r_idx   <= {IDX_W{1'b0}};
                        r_sum   <= {WIDTH{1'b0}};
                        r_cout  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_ADD;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_ADD: begin
                    // A stalled step freezes everything, including the nibble index.
                    if (!bus.hold) begin
                        r_sum[{r_idx, 2'b00} +: NIBBLE] <= w_slice_s;
                        r_carry <= w_slice_cout;
                        if (w_last) begin
                            r_cout  <= w_slice_cout;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                        end
                    end else begin
                        r_state <= ST_ADD;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Self-checking bench: directed corner cases plus randomized operations with random
// stalls, stuck start and back-to-back issue, checked against plain-arithmetic expectations.
module tb_cla_seq_adder_ctrl;
    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    cla_seq_adder_ctrl_if #(.WIDTH(WIDTH)) u_if ();

    cla_seq_adder_ctrl #(.WIDTH(WIDTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full operation; returns at the negedge where done is observed.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci,
                          input int hold_at, input int hold_len, input bit stuck,
                          input bit no_wait, output logic [WIDTH-1:0] exp_sum);
        logic [WIDTH:0] expv;
        int edges;
        int processed;
        int held;
        bit seen;
        expv    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
        exp_sum = expv[WIDTH-1:0];
        if (!no_wait) @(negedge clk);
        u_if.a     = a;
        u_if.b     = b;
        u_if.cin   = ci;
        u_if.start = 1'b1;
        u_if.hold  = 1'($urandom_range(0, 1));
        @(posedge clk);
        edges = 0; processed = 0; held = 0; seen = 1'b0;
        while (edges < 40) begin
            @(negedge clk);
            if (u_if.done) begin
                seen = 1'b1;
                break;
            end
            check("busy_in_add", {63'd0, u_if.busy}, 64'd1);
            u_if.start = stuck;
            u_if.a     = WIDTH'($urandom);
            u_if.b     = WIDTH'($urandom);
            u_if.cin   = 1'($urandom_range(0, 1));
            if (processed == hold_at && held < hold_len) begin
                u_if.hold = 1'b1;
                held++;
            end else begin
                u_if.hold = 1'b0;
                processed++;
            end
            @(posedge clk);
            edges++;
        end
        u_if.hold  = 1'b0;
        u_if.start = 1'b0;
        check("done_seen", {63'd0, seen}, 64'd1);
        check("latency", 64'(edges), 64'(N + held));
        check("busy_at_done", {63'd0, u_if.busy}, 64'd0);
        check("sum", 64'(u_if.sum), 64'(expv[WIDTH-1:0]));
        check("cout", {63'd0, u_if.cout}, {63'd0, expv[WIDTH]});
    endtask

    // Idle cycle after DONE: done drops, result held, hold has no effect.
    task automatic gap_check(input logic [WIDTH-1:0] exp_sum);
        u_if.hold = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("done_one_cycle", {63'd0, u_if.done}, 64'd0);
        check("busy_idle", {63'd0, u_if.busy}, 64'd0);
        check("sum_held", 64'(u_if.sum), 64'(exp_sum));
        u_if.hold = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] last_sum;
        bit chain;
        n_tests = 0;
        n_fail  = 0;
        rst        = 1'b1;
        u_if.start = 1'b0;
        u_if.hold  = 1'b0;
        u_if.a     = WIDTH'($urandom);
        u_if.b     = WIDTH'($urandom);
        u_if.cin   = 1'b1;
        #2;
        check("rst_busy", {63'd0, u_if.busy}, 64'd0);
        check("rst_done", {63'd0, u_if.done}, 64'd0);
        check("rst_sum", 64'(u_if.sum), 64'd0);
        check("rst_cout", {63'd0, u_if.cout}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(16'hFFFF, 16'h0001, 1'b0, 99, 0, 1'b0, 1'b0, last_sum);
        gap_check(last_sum);
        run_op(16'h1234, 16'h4321, 1'b1, 99, 0, 1'b0, 1'b0, last_sum);
        check("cin_sum_const", 64'(last_sum), 64'h5556);
        gap_check(last_sum);
        run_op(16'h8000, 16'h8000, 1'b0, 2, 2, 1'b0, 1'b0, last_sum);
        gap_check(last_sum);
        run_op(WIDTH'($urandom), WIDTH'($urandom), 1'b1, 99, 0, 1'b1, 1'b0, last_sum);
        run_op(16'h0F0F, 16'h00F1, 1'b0, 99, 0, 1'b0, 1'b1, last_sum);
        gap_check(last_sum);

        // Reset pulse mid-cycle while nibble 2 is in flight.
        @(negedge clk);
        u_if.a = 16'hFFFF; u_if.b = 16'hFFFF; u_if.cin = 1'b0; u_if.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        u_if.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", {63'd0, u_if.busy}, 64'd0);
        check("midrst_done", {63'd0, u_if.done}, 64'd0);
        check("midrst_sum", 64'(u_if.sum), 64'd0);
        check("midrst_cout", {63'd0, u_if.cout}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_no_done", {62'd0, u_if.done, u_if.busy}, 64'd0);
        end
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 99, 0, 1'b0, 1'b1, last_sum);
        gap_check(last_sum);

        for (int i = 0; i < 30; i++) begin
            chain = 1'($urandom_range(0, 1));
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), chain, last_sum);
            if ($urandom_range(0, 1) == 0) gap_check(last_sum);
        end
        gap_check(last_sum);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cla_seq_adder_ctrl.md
# cla_seq_adder_ctrl

Sequencer that performs a WIDTH-bit addition by time-multiplexing a single 4-bit carry-lookahead slice, one nibble per cycle, least-significant nibble first. The carry is registered between cycles. The block sits between a requester issuing start/operands and the shared 4-bit CLA datapath. It owns operand capture, nibble indexing, carry chaining, result assembly and completion signalling.

## Interface
- WIDTH, 16: operand/result width in bits; must be a multiple of 4 and ≥ 4. N = WIDTH/4 nibble steps.
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only in IDLE or DONE
- hold  in  1  stall; while high in ADD, no nibble is processed and all state is frozen
- a  in  WIDTH  operand A, captured on start acceptance
- b  in  WIDTH  operand B, captured on start acceptance
- cin  in  1  carry-in, captured on start acceptance
- busy  out  1  high while in ADD
- done  out  1  one-cycle pulse; result valid
- sum  out  WIDTH  registered result
- cout  out  1  registered final carry-out

## Operation
- States:
  - IDLE: start → ADD.
  - ADD: processes nibbles; after nibble N-1 → DONE.
  - DONE: start → ADD, else → IDLE.
- Start acceptance (IDLE/DONE with start=1):
  - latch a, b and cin into operand registers and the carry register;
  - idx ← 0;
  - sum ← 0, cout ← 0.
- Start in ADD is ignored. Operand inputs are don't-care outside the acceptance edge.
- ADD, hold=0, each edge:
  - slice inputs are a_reg[4·idx+3:4·idx], b_reg[same] and carry;
  - sum[4·idx+3:4·idx] ← slice sum;
  - carry ← slice cout;
  - idx ← idx+1.
- At idx = N-1, additionally cout ← slice cout, and state → DONE.
- ADD, hold=1: idx, carry, sum and state all hold.
- Arithmetic: {cout,sum} = a + b + cin exactly, modulo nothing (WIDTH+1-bit result).
- idx width is clog2(N), min 1. idx never exceeds N-1, with no wrap inside an operation.
- Partial nibbles are visible on sum during ADD. They are valid only when done=1 and are held afterwards until the next start acceptance.
- Reset (any time, including mid-ADD): immediately state=IDLE, busy=0, done=0, sum=0, cout=0, carry=0, idx=0, operand registers=0. An operation in flight is discarded.

## Timing
- Start sampled at edge t0 → busy=1 from t0 to t0+N+H, where H = cycles with hold=1 in ADD.
- done=1 for exactly the cycle after edge t0+N+H, with busy=0 in that cycle.
- Latency for WIDTH=16 with no hold: done is visible 4 edges after the start edge.
- Back-to-back: start=1 during the DONE cycle is accepted at the next edge. busy rises with no IDLE cycle in between, giving a throughput of one result per N+1 cycles.
- hold during IDLE/DONE has no effect. DONE always lasts exactly one cycle.
- Outputs busy, done, sum and cout are all registered, with no combinational path from inputs.

## Structure
- Shared package cla_ctrl_pkg:
  - state typedef {IDLE, ADD, DONE};
  - constant NIBBLE = 4;
  - function computing N and idx width from WIDTH.
- Sub-module cla4_slice: purely combinational 4-bit carry-lookahead adder (a[3:0], b[3:0], cin → s[3:0], cout) using generate/propagate terms. It is instantiated once. The controller holds all registers.
- Elaboration-time check: WIDTH % 4 == 0 and WIDTH ≥ 4, else fatal.

## Test plan
- Reset: assert rst mid-cycle with random inputs → busy=0, done=0, sum=0x0000, cout=0 without waiting for a clock edge.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0, one start pulse → busy high 4 cycles, single done pulse, sum=0x0000, cout=1.
- Carry-in use: a=0x1234, b=0x4321, cin=1 → done after 4 cycles, sum=0x5556, cout=0.
- Stall: a=0x8000, b=0x8000, cin=0, hold=1 for 2 cycles after nibble 1 → done delayed by exactly 2 cycles, sum=0x0000, cout=1.
- Start policy:
  - start held high with changing operands during ADD → ignored, result of first operands only;
  - start in DONE cycle with a=0x0F0F, b=0x00F1, cin=0 → accepted immediately, next result sum=0x1000, cout=0.
- Reset mid-operation: rst pulse during nibble 2 of 0xFFFF+0xFFFF → all outputs zero, no done. A subsequent start of 0xFFFF+0xFFFF+1 → sum=0xFFFF, cout=1.
